serial_rx: RTL and testbench

//  UART 8N1 receiver that turns the async serialIn pin into bytes and hands them over a valid/ready

---
 rtl/serial_pkg.sv | 23 ++
 rtl/rx_bit_timer.sv | 33 +++
 rtl/serial_rx.sv | 173 +++++++++++++++++
 tb/tb_serial_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link constants: FSM state encoding, default baud timing, ASCII codes.
// Used by serial_rx and by the tweetboard storage logic downstream.
package serial_pkg;

  localparam int SYSCLK_HZ            = 50_000_000;
  localparam int DEFAULT_BAUD         = 9600;
  localparam int DEFAULT_CLKS_PER_BIT = SYSCLK_HZ / DEFAULT_BAUD;
  localparam int DEFAULT_SYNC_STAGES  = 2;

  localparam int RX_STATE_W = 3;

  typedef enum logic [RX_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam logic [7:0] ASCII_BS = 8'h08;

endpackage

// File: rtl/rx_bit_timer.sv
// Purpose: bit-period counter with half-bit and full-bit strike flags, restartable.
// Latency: strikes are combinational from the counter register.
// Backpressure: none; free-running while restart is low.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic half_hit,
  output logic full_hit
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt;

  assign half_hit = (clk_cnt == HALF_LAST);
  assign full_hit = (clk_cnt == FULL_LAST);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      clk_cnt <= '0;
    end else if (restart || full_hit) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Purpose: UART receiver (8N1, or 8E1 with SERIAL_RX_PARITY_EN) into a one-byte valid/ready holding reg.
// Latency: rx_valid rises on the edge after the mid-stop-bit sample is taken.
// Backpressure: a full, unaccepted holding reg keeps its byte; the newer byte is dropped and overrun sticks.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("serial_rx: CLKS_PER_BIT must be >= 8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("serial_rx: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  rx_state_t              state_q, state_d;
  logic                   restart, half_hit, full_hit;
  logic [7:0]             shreg_q;
  logic [2:0]             bit_cnt_q;
  logic                   stop_load, stop_bad;
  logic                   par_bad;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serialIn};
    end
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart),
    .half_hit(half_hit),
    .full_hit(full_hit)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    restart   = 1'b0;
    stop_load = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (half_hit) begin
          restart = 1'b1;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_hit && (bit_cnt_q == 3'd7)) begin
`ifdef SERIAL_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (full_hit) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (full_hit) begin
          if (rxs) begin
            state_d   = ST_IDLE;
            stop_load = !par_bad;
          end else begin
            state_d  = ST_BREAK;
            stop_bad = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        restart = 1'b1;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if ((state_q == ST_START) && half_hit) begin
      bit_cnt_q <= '0;
    end else if ((state_q == ST_DATA) && full_hit) begin
      shreg_q   <= {rxs, shreg_q[7:1]};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic par_bad_q;
  logic par_mismatch;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_mismatch = ^{shreg_q, rxs};

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= (state_q == ST_PARITY) && full_hit && par_mismatch;
      if ((state_q == ST_PARITY) && full_hit) par_bad_q <= par_mismatch;
    end
  end
  assign par_bad = par_bad_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Holding register: a simultaneous accept frees the slot for the incoming byte.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (stop_load) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx at 16 clocks per bit; expected bytes queued as frames are sent.
// Parity scenario is compiled in with SERIAL_RX_PARITY_EN.
module tb_serial_rx;
  import serial_pkg::*;

  localparam int CPB = 16;

  logic       sysclk;
  logic       reset;
  logic       serialIn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int fe_cnt  = 0;
  int pe_cnt  = 0;
  int vld_cnt = 0;

  serial_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .serialIn  (serialIn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Monitor: records accepted bytes and flag pulse cycles, sampled away from the active edge.
  always @(negedge sysclk) begin
    if (reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) vld_cnt++;
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bit_out(input logic v, input int n);
    serialIn = v;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                            input logic stop);
    bit_out(1'b0, CPB);
    for (int i = 0; i < 8; i++) bit_out(d[i], CPB);
    if (use_par) bit_out(par, CPB);
    bit_out(stop, CPB);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    serialIn = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    reset = 1'b1;
    bit_out(1'b1, 2 * CPB);
  endtask

  task automatic test_single();
    int fe0;
    fe0 = fe_cnt;
    vld_cnt = 0;
    rx_ready = 1'b1;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b0, 1'b0, 1'b1);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", rx_busy); end
    bit_out(1'b1, 8);
    total++; if (vld_cnt !== 1) begin bad++; $display("FAIL single_vld_cycles got=%0d exp=1", vld_cnt); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL single_ferr got=%0d exp=0", fe_cnt - fe0); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL single_ovr got=%b exp=0", overrun); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL single_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    vld_cnt = 0;
    bit_out(1'b0, 3);
    bit_out(1'b1, 3 * CPB);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", rx_busy); end
    total++; if (vld_cnt !== 0) begin bad++; $display("FAIL glitch_vld got=%0d exp=0", vld_cnt); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    vld_cnt = 0;
    bit_out(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h7E;
      bit_out(d[i], CPB);
    end
    bit_out(1'b0, CPB + 64);
    bit_out(1'b1, 2 * CPB);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break_ferr_cycles got=%0d exp=1", fe_cnt - fe0); end
    total++; if (vld_cnt !== 0) begin bad++; $display("FAIL break_vld got=%0d exp=0", vld_cnt); end
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b0, 1'b0, 1'b1);
    bit_out(1'b1, 8);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL break_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL break_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b0;
    exp_q.push_back(ASCII_BS);
    send_frame(ASCII_BS, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    bit_out(1'b1, 8);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_held got=%b exp=1", rx_valid); end
    total++; if (rx_data !== ASCII_BS) begin bad++; $display("FAIL b2b_data_kept got=%h exp=%h", rx_data, ASCII_BS); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    rx_ready = 1'b1;
    @(posedge sysclk);
    #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b exp=0", rx_valid); end
    total++; if (rx_data !== ASCII_BS) begin bad++; $display("FAIL b2b_data_after got=%h exp=%h", rx_data, ASCII_BS); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    bit_out(1'b1, CPB);
  endtask

  task automatic test_midframe_reset();
    logic [7:0] a5;
    int fe0;
    a5 = 8'hA5;
    rx_ready = 1'b1;
    bit_out(1'b0, CPB);
    for (int i = 0; i < 4; i++) bit_out(a5[i], CPB);
    bit_out(a5[4], CPB / 2);
    reset = 1'b0;
    serialIn = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", rx_busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_ovr got=%b exp=0", overrun); end
    reset = 1'b1;
    bit_out(1'b1, 2 * CPB);
    fe0 = fe_cnt;
    vld_cnt = 0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    bit_out(1'b1, 8);
    total++; if (vld_cnt !== 1) begin bad++; $display("FAIL rst_mid_vld got=%0d exp=1", vld_cnt); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL rst_mid_ferr got=%0d exp=0", fe_cnt - fe0); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_ovr2 got=%b exp=0", overrun); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rst_mid_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    vld_cnt = 0;
    rx_ready = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    bit_out(1'b1, 8);
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_err_cycles got=%0d exp=1", pe_cnt - pe0); end
    total++; if (vld_cnt !== 0) begin bad++; $display("FAIL par_err_vld got=%0d exp=0", vld_cnt); end
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    bit_out(1'b1, 8);
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_ok_perr got=%0d exp=1", pe_cnt - pe0); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL par_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL par_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_back_to_back();
    test_midframe_reset();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    total++; if (pe_cnt > 1) begin bad++; $display("FAIL perr_total got=%0d exp<=1", pe_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
